// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the pipeline control blocks.
//   fetch_state_t : sequencing state of the fetch controller
//   CNT_W_DEFAULT : default width of the performance counters
//   max_u         : larger of two unsigned values (for parameter math)
// -----------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } fetch_state_t;

  localparam int unsigned CNT_W_DEFAULT = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk     : clock
//   i_clr   : synchronous clear (wins over increment)
//   i_inc   : increment enable
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter
  import pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// Sequences the instruction-fetch stage: PC enable / next-PC select and the
// IF/ID, ID/EX hold and squash controls. Covers the post-reset boot wait,
// load-use stalls, taken-branch redirects with bubble insertion and
// halt/resume. Keeps saturating counters of stall cycles and redirects.
//
// Ports
//   clk            : clock
//   resetn         : synchronous reset, active-high (despite the name)
//   load_use_stall : ID needs a one-cycle hold
//   ex_redirect    : EX resolved a taken branch/jump
//   halt_req       : ID decoded ecall/ebreak
//   resume         : leave HALTED
//   pc_write       : PC register enable
//   pc_src         : 0 = PC+4, 1 = redirect target
//   if_id_write    : IF/ID register enable
//   if_id_flush    : IF/ID loads a bubble
//   id_ex_flush    : ID/EX loads a bubble
//   halted         : core halted
//   stall_cycles   : saturating stall-cycle count
//   redirect_count : saturating accepted-redirect count
// -----------------------------------------------------------------------------
module fetch_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES      = 1,
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned CNT_W            = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_use_stall,
  input  logic             ex_redirect,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_write,
  output logic             pc_src,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  // The shared down-counter only ever holds (cycles - 1), so clog2 of the
  // larger cycle count is enough bits.
  localparam int unsigned SEQ_MAX = max_u(BOOT_CYCLES, REDIRECT_BUBBLES);
  localparam int unsigned SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
  localparam logic [SEQ_W-1:0] BOOT_LOAD     = SEQ_W'(BOOT_CYCLES - 1);
  localparam logic [SEQ_W-1:0] REDIRECT_LOAD = SEQ_W'(REDIRECT_BUBBLES - 1);

  fetch_state_t     r_state;
  logic [SEQ_W-1:0] r_seq_cnt;

  logic w_seq_zero;
  logic w_redirect_ok;
  logic w_accept_redirect;
  logic w_take_stall;

  assign w_seq_zero = (r_seq_cnt == '0);

  // Redirects are honoured from RUN and also from REDIRECT, so a second
  // taken branch resolving right behind the first is not lost.
  assign w_redirect_ok     = (r_state == RUN) || (r_state == REDIRECT);
  assign w_accept_redirect = !resetn && w_redirect_ok && ex_redirect;

  // A stall only counts when nothing of higher priority claims the cycle.
  assign w_take_stall = !resetn && (r_state == RUN) && !ex_redirect &&
                        !halt_req && load_use_stall;

  // ---------------------------------------------------------------------------
  // State sequencing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state   <= BOOT;
      r_seq_cnt <= BOOT_LOAD;
    end else begin
      unique case (r_state)
        BOOT: begin
          if (w_seq_zero) begin
            r_state <= RUN;
          end else begin
            r_seq_cnt <= r_seq_cnt - SEQ_W'(1);
          end
        end
        RUN: begin
          if (ex_redirect) begin
            r_state   <= REDIRECT;
            r_seq_cnt <= REDIRECT_LOAD;
          end else if (halt_req) begin
            r_state <= HALTED;
          end
        end
        REDIRECT: begin
          // halt_req / load_use_stall here come from squashed instructions.
          if (ex_redirect) begin
            r_seq_cnt <= REDIRECT_LOAD;
          end else if (w_seq_zero) begin
            r_state <= RUN;
          end else begin
            r_seq_cnt <= r_seq_cnt - SEQ_W'(1);
          end
        end
        HALTED: begin
          if (resume) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state   <= BOOT;
          r_seq_cnt <= BOOT_LOAD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Mealy control outputs: state plus same-cycle hazard inputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    if (resetn) begin
      if_id_flush = 1'b1;
    end else begin
      unique case (r_state)
        BOOT: begin
          if_id_flush = 1'b1;
        end
        RUN: begin
          if (ex_redirect) begin
            pc_write    = 1'b1;
            pc_src      = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (halt_req) begin
            // Freeze PC on the ecall/ebreak and stop feeding IF/ID.
            if_id_flush = 1'b1;
          end else if (load_use_stall) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        REDIRECT: begin
          if (ex_redirect) begin
            pc_write    = 1'b1;
            pc_src      = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            // Fetch keeps advancing from the target while the wrong-path
            // instruction in IF/ID is replaced by a bubble.
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end
        end
        HALTED: begin
          if_id_flush = 1'b1;
          halted      = 1'b1;
        end
        default: begin
          if_id_flush = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .i_clr   (resetn),
    .i_inc   (w_take_stall),
    .o_count (stall_cycles)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_redirect_cnt (
    .clk     (clk),
    .i_clr   (resetn),
    .i_inc   (w_accept_redirect),
    .o_count (redirect_count)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
// Two instances with different parameters driven by the same inputs. A
// behavioural model (boot/bubble countdowns, halted flag, event counts) gives
// the expected Mealy outputs and counter values.
// Output vector bit order: {pc_write, pc_src, if_id_write, if_id_flush,
// id_ex_flush, halted}.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

  localparam int unsigned A_BOOT = 1;
  localparam int unsigned A_RB   = 1;
  localparam int unsigned A_W    = 4;
  localparam int unsigned B_BOOT = 3;
  localparam int unsigned B_RB   = 2;
  localparam int unsigned B_W    = 16;

  typedef struct {
    int boot_left;
    int bub_left;
    bit halted;
    int stall;
    int redir;
    int p_boot;
    int p_rb;
    int cmax;
  } mdl_t;

  logic clk = 1'b0;
  logic resetn, lus, exr, hreq, res;

  logic a_pw, a_src, a_ifw, a_iff, a_idf, a_h;
  logic b_pw, b_src, b_ifw, b_iff, b_idf, b_h;
  logic [A_W-1:0] a_stall, a_red;
  logic [B_W-1:0] b_stall, b_red;
  logic [5:0] a_vec, b_vec;

  assign a_vec = {a_pw, a_src, a_ifw, a_iff, a_idf, a_h};
  assign b_vec = {b_pw, b_src, b_ifw, b_iff, b_idf, b_h};

  int n_pass  = 0;
  int n_total = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  fetch_controller #(.BOOT_CYCLES(A_BOOT), .REDIRECT_BUBBLES(A_RB), .CNT_W(A_W)) dut_a (
    .clk(clk), .resetn(resetn), .load_use_stall(lus), .ex_redirect(exr),
    .halt_req(hreq), .resume(res), .pc_write(a_pw), .pc_src(a_src),
    .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_flush(a_idf),
    .halted(a_h), .stall_cycles(a_stall), .redirect_count(a_red)
  );

  fetch_controller #(.BOOT_CYCLES(B_BOOT), .REDIRECT_BUBBLES(B_RB), .CNT_W(B_W)) dut_b (
    .clk(clk), .resetn(resetn), .load_use_stall(lus), .ex_redirect(exr),
    .halt_req(hreq), .resume(res), .pc_write(b_pw), .pc_src(b_src),
    .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_flush(b_idf),
    .halted(b_h), .stall_cycles(b_stall), .redirect_count(b_red)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic mdl_t model_reset(input mdl_t m);
    mdl_t n;
    n = m;
    n.boot_left = m.p_boot;
    n.bub_left  = 0;
    n.halted    = 1'b0;
    n.stall     = 0;
    n.redir     = 0;
    return n;
  endfunction

  // Returns {if_id_write_is_dont_care, expected output vector}.
  function automatic logic [6:0] model_exp(input mdl_t m, input logic r,
                                           input logic l, input logic x, input logic h);
    logic       dc;
    logic [5:0] v;
    dc = 1'b0;
    if (r)                    v = 6'b000100;
    else if (m.boot_left > 0) v = 6'b000100;
    else if (m.halted)        v = 6'b000101;
    else if (x)               begin v = 6'b111110; dc = 1'b1; end
    else if (m.bub_left > 0)  begin v = 6'b101100; dc = 1'b1; end
    else if (h)               begin v = 6'b000100; dc = 1'b1; end
    else if (l)               v = 6'b000010;
    else                      v = 6'b101000;
    return {dc, v};
  endfunction

  function automatic mdl_t model_step(input mdl_t m, input logic r, input logic l,
                                      input logic x, input logic h, input logic s);
    mdl_t n;
    n = m;
    if (r) begin
      n = model_reset(m);
    end else if (m.boot_left > 0) begin
      n.boot_left = m.boot_left - 1;
    end else if (m.halted) begin
      if (s) n.halted = 1'b0;
    end else if (x) begin
      n.bub_left = m.p_rb;
      if (m.redir < m.cmax) n.redir = m.redir + 1;
    end else if (m.bub_left > 0) begin
      n.bub_left = m.bub_left - 1;
    end else if (h) begin
      n.halted = 1'b1;
    end else if (l) begin
      if (m.stall < m.cmax) n.stall = m.stall + 1;
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change just after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic l, input logic x,
                       input logic h, input logic s);
    resetn = r; lus = l; exr = x; hreq = h; res = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    ma = model_step(ma, resetn, lus, exr, hreq, res);
    mb = model_step(mb, resetn, lus, exr, hreq, res);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [6:0] e;
    logic [5:0] msk;
    drive(1, 1, 1, 1, 1);
    n_total++;
    if (a_vec !== 6'b000100) $display("FAIL reset_outputs got %b want 000100", a_vec);
    else n_pass++;
    n_total++;
    if ({a_stall, a_red, b_stall, b_red} !== '0)
      $display("FAIL reset_counters got %h/%h/%h/%h want 0", a_stall, a_red, b_stall, b_red);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (a_vec !== 6'b000100) $display("FAIL boot_first got %b want 000100", a_vec);
    else n_pass++;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      if (i == 0) begin
        n_total++;
        if ({a_pw, a_src} !== 2'b10) $display("FAIL boot_release pc_write/pc_src got %b want 10", {a_pw, a_src});
        else n_pass++;
      end
      e   = model_exp(mb, resetn, lus, exr, hreq);
      msk = e[6] ? 6'b110111 : 6'b111111;
      n_total++;
      if ((b_vec & msk) !== (e[5:0] & msk))
        $display("FAIL boot_b cyc%0d got %b want %b", i, b_vec, e[5:0]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_load_use();
    int s0;
    s0 = ma.stall;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0);
      n_total++;
      if (a_vec !== 6'b000010) $display("FAIL load_use cyc%0d got %b want 000010", i, a_vec);
      else n_pass++;
      tick();
    end
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (a_vec !== 6'b101000) $display("FAIL load_use_release got %b want 101000", a_vec);
    else n_pass++;
    n_total++;
    if (a_stall !== A_W'(s0 + 2)) $display("FAIL load_use_count got %0d want %0d", a_stall, s0 + 2);
    else n_pass++;
    tick();
  endtask

  task automatic test_redirect();
    int s0, r0;
    s0 = ma.stall;
    r0 = ma.redir;
    drive(0, 1, 1, 0, 0);
    n_total++;
    if ((a_vec & 6'b110111) !== 6'b110110) $display("FAIL redirect_issue got %b want 11x110", a_vec);
    else n_pass++;
    tick();
    // stall and halt are from squashed instructions and must be ignored
    drive(0, 1, 0, 1, 0);
    n_total++;
    if ((a_vec & 6'b110111) !== 6'b100100) $display("FAIL redirect_bubble got %b want 10x100", a_vec);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (a_vec !== 6'b101000) $display("FAIL redirect_return got %b want 101000", a_vec);
    else n_pass++;
    n_total++;
    if (a_stall !== A_W'(s0) || a_red !== A_W'(r0 + 1))
      $display("FAIL redirect_counts got stall=%0d redir=%0d want %0d/%0d", a_stall, a_red, s0, r0 + 1);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = ma.redir;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 0);
      n_total++;
      if ((a_vec & 6'b110111) !== 6'b110110) $display("FAIL b2b_redirect cyc%0d got %b want 11x110", i, a_vec);
      else n_pass++;
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (a_red !== A_W'(r0 + 2) || a_vec !== 6'b101000)
      $display("FAIL b2b_count got redir=%0d vec=%b want %0d/101000", a_red, a_vec, r0 + 2);
    else n_pass++;
    tick();
  endtask

  task automatic test_halt();
    int r0;
    drive(0, 0, 0, 1, 0);
    n_total++;
    if ((a_vec & 6'b110111) !== 6'b000100) $display("FAIL halt_enter got %b want 00x100", a_vec);
    else n_pass++;
    tick();
    r0 = ma.redir;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 1'(i % 2 == 0), 1'($urandom_range(0, 1)), 0);
      n_total++;
      if (a_vec !== 6'b000101) $display("FAIL halt_hold cyc%0d got %b want 000101", i, a_vec);
      else n_pass++;
      tick();
    end
    n_total++;
    if (a_red !== A_W'(r0)) $display("FAIL halt_redirect_ignored got %0d want %0d", a_red, r0);
    else n_pass++;
    // resume and halt_req together: resume wins
    drive(0, 0, 0, 1, 1);
    n_total++;
    if (a_vec !== 6'b000101) $display("FAIL halt_resume_cycle got %b want 000101", a_vec);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (a_vec !== 6'b101000) $display("FAIL halt_resumed got %b want 101000", a_vec);
    else n_pass++;
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (a_stall !== 4'hF) $display("FAIL sat_stall got %0d want 15", a_stall);
    else n_pass++;
    n_total++;
    if (b_stall !== B_W'(mb.stall)) $display("FAIL sat_stall_b got %0d want %0d", b_stall, mb.stall);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 1, 1, 0);
    n_total++;
    if (a_vec !== 6'b000100) $display("FAIL rst_mid_redirect_out got %b want 000100", a_vec);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0);
    n_total++;
    if ({a_stall, a_red, b_stall, b_red} !== '0)
      $display("FAIL rst_mid_counters got %h/%h/%h/%h want 0", a_stall, a_red, b_stall, b_red);
    else n_pass++;
    n_total++;
    if (a_vec !== 6'b000100) $display("FAIL rst_mid_boot got %b want 000100", a_vec);
    else n_pass++;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (a_vec !== 6'b000100 || b_vec !== 6'b000100)
      $display("FAIL rst_mid_halt got a=%b b=%b want 000100", a_vec, b_vec);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ea, eb;
    logic [5:0] mska, mskb;
    logic r, l, x, h, s;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 2) == 0);
      x = ($urandom_range(0, 4) == 0);
      h = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0);
      drive(r, l, x, h, s);
      ea   = model_exp(ma, r, l, x, h);
      eb   = model_exp(mb, r, l, x, h);
      mska = ea[6] ? 6'b110111 : 6'b111111;
      mskb = eb[6] ? 6'b110111 : 6'b111111;
      n_total++;
      if ((a_vec & mska) !== (ea[5:0] & mska))
        $display("FAIL rand_a cyc%0d in=%b%b%b%b%b got %b want %b", i, r, l, x, h, s, a_vec, ea[5:0]);
      else n_pass++;
      n_total++;
      if ((b_vec & mskb) !== (eb[5:0] & mskb))
        $display("FAIL rand_b cyc%0d in=%b%b%b%b%b got %b want %b", i, r, l, x, h, s, b_vec, eb[5:0]);
      else n_pass++;
      n_total++;
      if (a_stall !== A_W'(ma.stall) || a_red !== A_W'(ma.redir))
        $display("FAIL rand_cnt_a cyc%0d got %0d/%0d want %0d/%0d", i, a_stall, a_red, ma.stall, ma.redir);
      else n_pass++;
      n_total++;
      if (b_stall !== B_W'(mb.stall) || b_red !== B_W'(mb.redir))
        $display("FAIL rand_cnt_b cyc%0d got %0d/%0d want %0d/%0d", i, b_stall, b_red, mb.stall, mb.redir);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    resetn = 1'b1; lus = 1'b0; exr = 1'b0; hreq = 1'b0; res = 1'b0;
    ma.p_boot = A_BOOT; ma.p_rb = A_RB; ma.cmax = (1 << A_W) - 1;
    mb.p_boot = B_BOOT; mb.p_rb = B_RB; mb.cmax = (1 << B_W) - 1;
    ma = model_reset(ma);
    mb = model_reset(mb);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_redirect();
    test_back_to_back();
    test_halt();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
